uart_rx_engine: RTL

- Serial UART receiver. It recovers bytes sent by the team's transmitter engine on the TX line.
- Frame format: start (0), 8 data bits LSB-first, odd parity bit, stop (1).
- It oversamples the asynchronous RX pin, samples each bit at mid-bit, and checks parity and stop.
- It presents each byte with error flags to the APB register block.

---
 rtl/uart_rx_engine.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: 8-O-1 UART receiver with mid-bit sampling, parity/stop checking; define UART_RX_OVERRUN_EN for level rx_valid with rx_ack and sticky overrun
module uart_rx_engine #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_END = CNT_W'(CLKS_PER_BIT);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             stop_q, stop_d;
    logic [7:0]       data_q, data_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             rx_m_q, rx_s_q, rx_p_q;
    logic             fall, deliver, parity_ok;
    assign fall      = rx_p_q & ~rx_s_q;
    assign parity_ok = (^shift_q) ^ par_q;
    assign data_out   = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = state_q != IDLE;
    // two-flop synchronizer plus previous-sample register, all idling high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_p_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
            rx_p_q <= rx_s_q;
        end
    end
    // frame sequencing: start qualify at half bit, then one sample per bit period
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop_d  = stop_q;
        deliver = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: if (cnt_q == HALF_END) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_END) begin
                cnt_d          = '0;
                shift_d[idx_q] = rx_s_q;
                idx_d          = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                par_d   = rx_s_q;
                state_d = STOP;
            end
            STOP: begin
                if (cnt_q == BIT_END) stop_d = rx_s_q;
                if (cnt_q == STOP_END) begin
                    deliver = 1'b1;
                    cnt_d   = '0;
                    state_d = fall ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // delivery registers; flags are recomputed each frame
    always_comb begin
        data_d = deliver ? shift_q : data_q;
        perr_d = deliver ? ~parity_ok : perr_q;
        ferr_d = deliver ? ~stop_q : ferr_q;
`ifdef UART_RX_OVERRUN_EN
        valid_d = deliver | (valid_q & ~rx_ack);
        ovr_d   = rx_ack ? 1'b0 : (ovr_q | (deliver & valid_q));
`else
        valid_d = deliver;
        ovr_d   = 1'b0;
`endif
    end
`ifndef UART_RX_OVERRUN_EN
    logic unused_ack;
    assign unused_ack = rx_ack;
`endif
    // state and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule
